// File: rtl/stream_packer_pkg.sv
// Shared defaults and helpers for the stream packer slice.
package stream_packer_pkg;

   localparam int DEF_IN_W  = 32;
   localparam int DEF_RATIO = 4;
   localparam int DEF_CNT_W = 16;

   // Width of a lane index; never narrower than one bit so RATIO=1 still
   // gets a legal counter.
   function automatic int lane_idx_w(input int ratio);
      return (ratio > 1) ? $clog2(ratio) : 1;
   endfunction

endpackage

// File: rtl/packer_out_reg.sv
// Single-entry valid/ready holding register for closed words.
module packer_out_reg #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         enable_i,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic [W-1:0] data_q;

   // A load wins over a pop so a word can be replaced in the same cycle it
   // leaves; an emptied register reads back as all zeros.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (clr_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end else if (valid_q && enable_i && ready_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/stream_packer.sv
// Packs RATIO narrow input beats into one wide output word with lane strobes.
module stream_packer
   import stream_packer_pkg::*;
#(
   parameter int IN_W      = DEF_IN_W,
   parameter int RATIO     = DEF_RATIO,
   parameter int MSB_FIRST = 1,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int OUT_W     = IN_W * RATIO
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic             enable_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [IN_W-1:0]  in_data_i,
   input  logic             in_last_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [OUT_W-1:0] out_data_o,
   output logic [RATIO-1:0] out_strb_o,
   output logic             out_last_o,
   output logic [CNT_W-1:0] words_o
);

   localparam int LANE_W = lane_idx_w(RATIO);
   localparam int OREG_W = OUT_W + RATIO + 1;

   logic [LANE_W-1:0] cnt;
   logic [OUT_W-1:0]  asm_data;
   logic [RATIO-1:0]  asm_strb;
   logic [OUT_W-1:0]  beat_lanes;
   logic [RATIO-1:0]  beat_strb;
   logic              out_valid_r;
   logic [OREG_W-1:0] oreg_q;
   logic              in_xfer;
   logic              out_xfer;
   logic              close_word;

   assign in_ready_o  = enable_i & ~clr_i & (~out_valid_r | out_ready_i);
   assign in_xfer     = in_valid_i & in_ready_o;
   assign out_valid_o = out_valid_r & enable_i;
   assign out_xfer    = out_valid_o & out_ready_i & ~clr_i;
   assign close_word  = in_xfer & ((cnt == LANE_W'(RATIO - 1)) | in_last_i);

   // Steer the incoming beat into the lane selected by the current count.
   always_comb begin
      beat_lanes = '0;
      beat_strb  = '0;
      for (int k = 0; k < RATIO; k++) begin
         if (cnt == LANE_W'(k)) begin
            if (MSB_FIRST != 0) begin
               beat_lanes[(RATIO-1-k)*IN_W +: IN_W] = in_data_i;
            end else begin
               beat_lanes[k*IN_W +: IN_W] = in_data_i;
            end
            beat_strb[k] = 1'b1;
         end
      end
   end

   // Assembly stage: accumulate beats until a word closes, then start clean.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt      <= '0;
         asm_data <= '0;
         asm_strb <= '0;
      end else if (clr_i) begin
         cnt      <= '0;
         asm_data <= '0;
         asm_strb <= '0;
      end else if (in_xfer) begin
         if (close_word) begin
            cnt      <= '0;
            asm_data <= '0;
            asm_strb <= '0;
         end else begin
            cnt      <= cnt + 1'b1;
            asm_data <= asm_data | beat_lanes;
            asm_strb <= asm_strb | beat_strb;
         end
      end
   end

   // Emitted-word counter, wraps naturally at its width.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         words_o <= '0;
      end else if (clr_i) begin
         words_o <= '0;
      end else if (out_xfer) begin
         words_o <= words_o + 1'b1;
      end
   end

   packer_out_reg #(
      .W(OREG_W)
   ) u_out_reg (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (clr_i),
      .enable_i(enable_i),
      .load_i  (close_word),
      .data_i  ({asm_data | beat_lanes, asm_strb | beat_strb, in_last_i}),
      .ready_i (out_ready_i),
      .valid_o (out_valid_r),
      .data_o  (oreg_q)
   );

   assign {out_data_o, out_strb_o, out_last_o} = oreg_q;

endmodule

// File: tb/tb_stream_packer.sv
// Scoreboard bench: stimulus pushes expected words, a monitor pops on transfer.
module tb_stream_packer;

   localparam int IN_W  = 32;
   localparam int RATIO = 4;
   localparam int CNT_W = 16;
   localparam int OUT_W = IN_W * RATIO;

   typedef struct {
      logic [OUT_W-1:0] msb;
      logic [OUT_W-1:0] lsb;
      logic [RATIO-1:0] strb;
      logic             last;
   } exp_t;

   exp_t exp_q[$];
   int   check_count = 0;
   int   pass_count  = 0;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr = 1'b0;
   logic             enable = 1'b1;
   logic             in_valid = 1'b0;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_last = 1'b0;
   logic             out_ready = 1'b1;
   logic             in_ready, in_ready_lsb;
   logic             out_valid, out_valid_lsb;
   logic [OUT_W-1:0] out_data, out_data_lsb;
   logic [RATIO-1:0] out_strb, out_strb_lsb;
   logic             out_last, out_last_lsb;
   logic [CNT_W-1:0] words, words_lsb;

   stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1), .CNT_W(CNT_W)) dut_msb (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(enable),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_strb_o(out_strb), .out_last_o(out_last), .words_o(words)
   );

   stream_packer #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0), .CNT_W(CNT_W)) dut_lsb (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .enable_i(enable),
      .in_valid_i(in_valid), .in_ready_o(in_ready_lsb), .in_data_i(in_data), .in_last_i(in_last),
      .out_valid_o(out_valid_lsb), .out_ready_i(out_ready), .out_data_o(out_data_lsb),
      .out_strb_o(out_strb_lsb), .out_last_o(out_last_lsb), .words_o(words_lsb)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [OUT_W-1:0] actual,
                              input logic [OUT_W-1:0] expected);
      check_count++;
      if (actual === expected) pass_count++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
   endtask

   task automatic expectWord(input logic [OUT_W-1:0] msb, input logic [OUT_W-1:0] lsb,
                             input logic [RATIO-1:0] strb, input logic last);
      exp_t e;
      e.msb = msb; e.lsb = lsb; e.strb = strb; e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic [IN_W-1:0] data, input logic last);
      int   waited = 0;
      logic accepted = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; in_data = data; in_last = last;
      while (!accepted && waited < 200) begin
         #1;
         if (in_ready) accepted = 1'b1;
         else begin
            waited++;
            @(negedge clk);
         end
      end
      if (!accepted) begin
         check_count++;
         $display("[TB] FAIL accept_timeout: beat %h not accepted, expected acceptance", data);
      end
      @(posedge clk);
   endtask

   task automatic idleInputs();
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0; in_data = '0;
   endtask

   task automatic waitDrain();
      int n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk); #3;
         n++;
      end
      if (n >= 200) begin
         check_count++;
         $display("[TB] FAIL drain_timeout: %0d words pending, expected 0", exp_q.size());
      end
   endtask

   task automatic waitValid();
      int n = 0;
      while (!out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         check_count++;
         $display("[TB] FAIL valid_timeout: out_valid 0, expected 1");
      end
   endtask

   task automatic resetDut();
      @(negedge clk); rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every output transfer must match the oldest expected word.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk); #2;
         if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_count++;
               $display("[TB] FAIL unexpected_word: got %h, expected no word", out_data);
            end else begin
               e = exp_q.pop_front();
               checkOutput("data_msb", out_data, e.msb);
               checkOutput("data_lsb", out_data_lsb, e.lsb);
               checkOutput("strb", OUT_W'(out_strb), OUT_W'(e.strb));
               checkOutput("last", OUT_W'(out_last), OUT_W'(e.last));
               checkOutput("strb_lsb", OUT_W'(out_strb_lsb), OUT_W'(e.strb));
               checkOutput("last_lsb", OUT_W'(out_last_lsb), OUT_W'(e.last));
               checkOutput("valid_lsb", OUT_W'(out_valid_lsb), 1);
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state
      @(negedge clk); #1;
      checkOutput("rst_valid", OUT_W'(out_valid), 0);
      checkOutput("rst_strb", OUT_W'(out_strb), 0);
      checkOutput("rst_last", OUT_W'(out_last), 0);
      checkOutput("rst_words", OUT_W'(words), 0);
      @(negedge clk); rst_n = 1'b1; #1;
      checkOutput("rst_in_ready", OUT_W'(in_ready), 1);

      // Full word, back to back, one-cycle latency
      expectWord(128'h0000000A_0000000B_0000000C_0000000D,
                 128'h0000000D_0000000C_0000000B_0000000A, 4'hF, 1'b0);
      applyStimulus(32'hA, 1'b0);
      applyStimulus(32'hB, 1'b0);
      applyStimulus(32'hC, 1'b0);
      applyStimulus(32'hD, 1'b0);
      @(negedge clk); in_valid = 1'b0; #1;
      checkOutput("latency", OUT_W'(out_valid), 1);
      waitDrain();

      // Early flush after two beats
      expectWord(128'h00000011_00000022_00000000_00000000,
                 128'h00000000_00000000_00000022_00000011, 4'b0011, 1'b1);
      applyStimulus(32'h11, 1'b0);
      applyStimulus(32'h22, 1'b1);
      idleInputs();
      waitDrain();

      // Flush on the very first lane
      expectWord(128'h00000055_00000000_00000000_00000000,
                 128'h00000000_00000000_00000000_00000055, 4'b0001, 1'b1);
      applyStimulus(32'h55, 1'b1);
      idleInputs();
      waitDrain();
      checkOutput("words_after3", OUT_W'(words), 3);

      // Continuous twelve beats with a three-cycle consumer stall
      resetDut();
      expectWord(128'h00000001_00000002_00000003_00000004,
                 128'h00000004_00000003_00000002_00000001, 4'hF, 1'b0);
      expectWord(128'h00000005_00000006_00000007_00000008,
                 128'h00000008_00000007_00000006_00000005, 4'hF, 1'b0);
      expectWord(128'h00000009_0000000A_0000000B_0000000C,
                 128'h0000000C_0000000B_0000000A_00000009, 4'hF, 1'b0);
      fork
         begin
            for (int i = 1; i <= 12; i++) applyStimulus(32'(i), 1'b0);
            idleInputs();
         end
         begin
            int n = 0;
            @(negedge clk);
            while (!out_valid && n < 200) begin
               @(negedge clk);
               n++;
            end
            out_ready = 1'b0;
            for (int c = 0; c < 3; c++) begin
               #2;
               checkOutput("stall_in_ready", OUT_W'(in_ready), 0);
               checkOutput("stall_in_ready_lsb", OUT_W'(in_ready_lsb), 0);
               checkOutput("stall_out_valid", OUT_W'(out_valid), 1);
               @(negedge clk);
            end
            out_ready = 1'b1;
            #2;
            checkOutput("release_in_ready", OUT_W'(in_ready), 1);
         end
      join
      waitDrain();
      checkOutput("words_stream", OUT_W'(words), 3);
      checkOutput("words_stream_lsb", OUT_W'(words_lsb), 3);

      // Clear discards a partial word
      resetDut();
      applyStimulus(32'hE1, 1'b0);
      applyStimulus(32'hE2, 1'b0);
      @(negedge clk); in_valid = 1'b0; clr = 1'b1; #1;
      checkOutput("clr_in_ready", OUT_W'(in_ready), 0);
      @(negedge clk); clr = 1'b0;
      expectWord(128'h000000F1_000000F2_000000F3_000000F4,
                 128'h000000F4_000000F3_000000F2_000000F1, 4'hF, 1'b0);
      applyStimulus(32'hF1, 1'b0);
      applyStimulus(32'hF2, 1'b0);
      applyStimulus(32'hF3, 1'b0);
      applyStimulus(32'hF4, 1'b0);
      idleInputs();
      waitDrain();
      checkOutput("words_clr", OUT_W'(words), 1);

      // Enable low freezes a pending word
      @(negedge clk); out_ready = 1'b0;
      expectWord(128'h00000031_00000032_00000033_00000034,
                 128'h00000034_00000033_00000032_00000031, 4'hF, 1'b0);
      applyStimulus(32'h31, 1'b0);
      applyStimulus(32'h32, 1'b0);
      applyStimulus(32'h33, 1'b0);
      applyStimulus(32'h34, 1'b0);
      idleInputs();
      waitValid();
      enable = 1'b0; #1;
      checkOutput("en_out_valid", OUT_W'(out_valid), 0);
      checkOutput("en_in_ready", OUT_W'(in_ready), 0);
      @(negedge clk); out_ready = 1'b1; #1;
      checkOutput("en_out_valid_ready", OUT_W'(out_valid), 0);
      checkOutput("en_words_frozen", OUT_W'(words), 1);
      @(negedge clk); enable = 1'b1;
      waitDrain();
      checkOutput("words_en", OUT_W'(words), 2);

      // Asynchronous reset with a word pending, then mid-word
      resetDut();
      expectWord(128'h00000041_00000042_00000043_00000044,
                 128'h00000044_00000043_00000042_00000041, 4'hF, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(32'h41 + 32'(i), 1'b0);
      idleInputs();
      waitDrain();
      checkOutput("words_pre_rst", OUT_W'(words), 1);
      @(negedge clk); out_ready = 1'b0;
      for (int i = 0; i < 4; i++) applyStimulus(32'h51 + 32'(i), 1'b0);
      idleInputs();
      waitValid();
      rst_n = 1'b0; #1;
      checkOutput("arst_out_valid", OUT_W'(out_valid), 0);
      checkOutput("arst_words", OUT_W'(words), 0);
      checkOutput("arst_strb", OUT_W'(out_strb), 0);
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      applyStimulus(32'h61, 1'b0);
      applyStimulus(32'h62, 1'b0);
      idleInputs();
      resetDut();
      expectWord(128'h00000071_00000072_00000073_00000074,
                 128'h00000074_00000073_00000072_00000071, 4'hF, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(32'h71 + 32'(i), 1'b0);
      idleInputs();
      waitDrain();
      checkOutput("words_post_rst", OUT_W'(words), 1);

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/stream_packer.md
STREAM_PACKER -- requirements
Module: stream_packer

Interface
REQ-001 SHALL have parameter IN_W, default 32, input beat width in bits.
REQ-002 SHALL have parameter RATIO, default 4, input beats per output word (>=1).
REQ-003 SHALL have parameter MSB_FIRST, default 1, with 1 placing the first beat in the most-significant lane.
REQ-004 SHALL have parameter CNT_W, default 16, emitted-word counter width.
REQ-005 SHALL derive OUT_W = IN_W*RATIO.
REQ-006 SHALL have one clock and asynchronous active-low reset: clk_i  in  1  clock; rst_ni  in  1  async reset, active low.
REQ-007 clr_i  in  1  synchronous clear.
REQ-008 enable_i  in  1  global enable.
REQ-009 in_valid_i  in  1  input beat valid.
REQ-010 in_ready_o  out  1  input beat accepted when high with in_valid_i.
REQ-011 in_data_i  in  IN_W  input beat.
REQ-012 in_last_i  in  1  flush: close the word after this beat.
REQ-013 out_valid_o  out  1  packed word valid.
REQ-014 out_ready_i  in  1  consumer ready.
REQ-015 out_data_o  out  OUT_W  packed word.
REQ-016 out_strb_o  out  RATIO  filled-lane mask, bit k = beat k.
REQ-017 out_last_o  out  1  word closed by in_last_i.
REQ-018 words_o  out  CNT_W  count of emitted words.

Function
REQ-019 Input transfer = in_valid_i & in_ready_o; output transfer = out_valid_o & out_ready_i.
REQ-020 Two stages: assembly register (lane counter cnt, data, strb) and output register; one beat per cycle while output is not stalled.
REQ-021 in_ready_o = enable_i & ~clr_i & (~out_valid_r | out_ready_i); no dependence on in_valid_i or in_data_i.
REQ-022 Accepted beat at lane cnt: MSB_FIRST=1 -> bits [OUT_W-1-cnt*IN_W -: IN_W]; MSB_FIRST=0 -> bits [cnt*IN_W +: IN_W]; strb[cnt] set.
REQ-023 Beat closes word when cnt==RATIO-1 or in_last_i=1; closed word (data, strb, last=in_last_i) loads the output register in the same edge, assembly cleared to zero, cnt -> 0.
REQ-024 Otherwise cnt increments by 1; unfilled lanes SHALL read zero in out_data_o.
REQ-025 Latency: word closed at edge t -> out_valid_o high from cycle after t; no combinational input-to-output path.
REQ-026 Output transfer with no new close: out_valid_r -> 0, out_data/strb/last -> 0.
REQ-027 Output transfer and close in the same cycle: output register reloads with the new word, out_valid_o stays 1 (no bubble).
REQ-028 words_o increments by 1 per output transfer, wrapping from 2^CNT_W-1 to 0.
REQ-029 out_valid_o = out_valid_r & enable_i; enable_i low freezes all state, blocks both transfers.
REQ-030 clr_i high: all state zeroed at next edge, including words_o; clr_i has priority over enable_i and any transfer.
REQ-031 in_last_i on a beat with cnt==0 SHALL emit a single-lane word (strb = lane 0 only).
REQ-032 RATIO=1: every beat closes a word; strb constant 1.

Reset
REQ-033 On rst_ni low, asynchronously: cnt=0, assembly and output registers 0, out_valid_o=0, out_strb_o=0, out_last_o=0, words_o=0; in_ready_o=enable_i after release.
REQ-034 Reset mid-word SHALL discard the partial word without emitting it.

Structure
REQ-035 Package stream_packer_pkg SHALL hold default IN_W, RATIO, CNT_W and a lane-index width function (min 1 bit).
REQ-036 Output register stage SHALL be sub-module packer_out_reg (valid/ready register, OUT_W+RATIO+1 bits).

Verification
REQ-037 IN_W=32, RATIO=4, MSB_FIRST=1: beats 0xA,0xB,0xC,0xD back-to-back, out_ready_i=1 -> out_data_o=0x0000000A_0000000B_0000000C_0000000D, strb=4'hF, last=0, one cycle after fourth beat.
REQ-038 MSB_FIRST=0, same beats -> out_data_o=0x0000000D_0000000C_0000000B_0000000A.
REQ-039 Beats 0x11,0x22 with in_last_i on 0x22 -> data=0x00000011_00000022_00000000_00000000, strb=4'b0011, last=1.
REQ-040 Continuous 12 beats, out_ready_i low 3 cycles after first word -> in_ready_o low exactly while output full; 3 words emitted in order, words_o=3.
REQ-041 clr_i asserted after 2 beats -> no word emitted; next 4 beats form a clean word with strb=4'hF.
REQ-042 rst_ni pulsed with out_valid_o=1 -> out_valid_o=0 immediately, words_o=0.
